// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit saturating counters; predicts at
//               fetch and checks jump outcomes resolved at write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_if,
  output logic            jump_pred,
  output logic [PC_W-1:0] pred_adr,
  input  logic            resolve_valid,
  input  logic [PC_W-1:0] resolve_pc,
  input  logic            resolve_taken,
  input  logic [PC_W-1:0] resolve_target,
  input  logic            resolve_pred,
  input  logic [PC_W-1:0] resolve_pred_adr,
  output logic            jump_pred_miss,
  output logic            jump_pred_adr_miss,
  output logic [PC_W-1:0] correct_pc,
  output logic            jump_pred_busy
);

  localparam int               ENTRIES  = 2**IDX_W;
  localparam int               TAG_W    = PC_W - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_UPD   = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_clr_idx;
  logic [PC_W-1:0]   r_upd_pc;
  logic              r_upd_taken;
  logic [PC_W-1:0]   r_upd_tgt;

  logic              r_valid [ENTRIES];
  logic [TAG_W-1:0]  r_tag   [ENTRIES];
  logic [PC_W-1:0]   r_tgt   [ENTRIES];
  logic [1:0]        r_ctr   [ENTRIES];

  logic [IDX_W-1:0]  w_lk_idx;
  logic              w_lk_hit;
  logic [IDX_W-1:0]  w_up_idx;
  logic [TAG_W-1:0]  w_up_tag;
  logic              w_up_hit;
  logic [1:0]        w_up_ctr;
  logic [1:0]        w_ctr_nxt;
  logic              w_chk;

  // Lookup
  assign w_lk_idx  = pc_if[IDX_W-1:0];
  assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == pc_if[PC_W-1:IDX_W]);
  assign jump_pred = w_lk_hit && r_ctr[w_lk_idx][1] && (r_state == S_IDLE);
  assign pred_adr  = (w_lk_hit && rst_n) ? r_tgt[w_lk_idx] : '0;
  assign jump_pred_busy = (r_state != S_IDLE);

  // Resolution check; outputs stay live in UPD even though the update is dropped
  assign w_chk              = resolve_valid && (r_state != S_CLEAR);
  assign jump_pred_miss     = w_chk && (resolve_pred != resolve_taken);
  assign jump_pred_adr_miss = w_chk && resolve_pred && resolve_taken &&
                              (resolve_target != resolve_pred_adr);
  assign correct_pc = !w_chk        ? '0 :
                      resolve_taken ? resolve_target :
                                      resolve_pc + PC_W'(1);

  // Pending update decode
  assign w_up_idx = r_upd_pc[IDX_W-1:0];
  assign w_up_tag = r_upd_pc[PC_W-1:IDX_W];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_ctr = r_ctr[w_up_idx];

  always_comb begin
    w_ctr_nxt = w_up_ctr;
    if (r_upd_taken) begin
      if (w_up_ctr != 2'b11) w_ctr_nxt = w_up_ctr + 2'b01;
    end else begin
      if (w_up_ctr != 2'b00) w_ctr_nxt = w_up_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CLEAR;
      r_clr_idx   <= '0;
      r_upd_pc    <= '0;
      r_upd_taken <= 1'b0;
      r_upd_tgt   <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_idx <= r_clr_idx + IDX_W'(1);
          if (r_clr_idx == LAST_IDX) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (resolve_valid) begin
            r_upd_pc    <= resolve_pc;
            r_upd_taken <= resolve_taken;
            r_upd_tgt   <= resolve_target;
            r_state     <= S_UPD;
          end
        end
        S_UPD:   r_state <= S_IDLE;
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Table storage has no reset; the CLEAR sweep invalidates it
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_valid[r_clr_idx] <= 1'b0;
    end else if (r_state == S_UPD) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_nxt;
        if (r_upd_taken) r_tgt[w_up_idx] <= r_upd_tgt;
      end else if (r_upd_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_tag[w_up_idx]   <= w_up_tag;
        r_tgt[w_up_idx]   <= r_upd_tgt;
        r_ctr[w_up_idx]   <= 2'b10;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed bench for branch_predictor with a behavioural BTB model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
  localparam int ENT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_if;
  logic        jump_pred;
  logic [15:0] pred_adr;
  logic        resolve_valid;
  logic [15:0] resolve_pc;
  logic        resolve_taken;
  logic [15:0] resolve_target;
  logic        resolve_pred;
  logic [15:0] resolve_pred_adr;
  logic        jump_pred_miss;
  logic        jump_pred_adr_miss;
  logic [15:0] correct_pc;
  logic        jump_pred_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(4), .PC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .jump_pred(jump_pred), .pred_adr(pred_adr),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .resolve_pred(resolve_pred),
    .resolve_pred_adr(resolve_pred_adr), .jump_pred_miss(jump_pred_miss),
    .jump_pred_adr_miss(jump_pred_adr_miss), .correct_pc(correct_pc),
    .jump_pred_busy(jump_pred_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: table contents, clearing progress, one pending update
  bit m_valid [ENT];
  int m_tag   [ENT];
  int m_tgt   [ENT];
  int m_ctr   [ENT];
  bit m_clearing = 1'b1;
  bit m_known    = 1'b0;
  bit m_pend     = 1'b0;
  int m_clr_cnt  = 0;
  int m_ppc, m_ptgt;
  bit m_ptaken;
  bit run_chk = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clearing = 1'b1;
      m_clr_cnt  = 0;
      m_pend     = 1'b0;
    end else if (m_clearing) begin
      m_valid[m_clr_cnt] = 1'b0;
      m_clr_cnt++;
      if (m_clr_cnt == ENT) begin
        m_clearing = 1'b0;
        m_known    = 1'b1;
      end
    end else if (m_pend) begin
      int i;
      i = m_ppc % ENT;
      if (m_valid[i] && m_tag[i] == m_ppc / ENT) begin
        if (m_ptaken) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = m_ptgt;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (m_ptaken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = m_ppc / ENT;
        m_tgt[i]   = m_ptgt;
        m_ctr[i]   = 2;
      end
      m_pend = 1'b0;
    end else if (resolve_valid) begin
      m_pend   = 1'b1;
      m_ppc    = int'(resolve_pc);
      m_ptaken = resolve_taken;
      m_ptgt   = int'(resolve_target);
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      bit e_busy, e_hit, e_act;
      int i, e_cpc;
      e_busy = !rst_n || m_clearing || m_pend;
      i      = int'(pc_if) % ENT;
      e_hit  = m_known && !m_clearing && m_valid[i] && (m_tag[i] == int'(pc_if) / ENT);
      chk("busy", jump_pred_busy, e_busy);
      chk("jump_pred", jump_pred, !e_busy && e_hit && m_ctr[i] >= 2);
      if (!rst_n || !m_clearing) chk("pred_adr", pred_adr, e_hit ? m_tgt[i] : 0);
      e_act = rst_n && !m_clearing && resolve_valid;
      e_cpc = !e_act ? 0 : resolve_taken ? int'(resolve_target) : (int'(resolve_pc) + 1) % 65536;
      chk("miss", jump_pred_miss, e_act && (resolve_pred != resolve_taken));
      chk("adr_miss", jump_pred_adr_miss,
          e_act && resolve_pred && resolve_taken && (resolve_target != resolve_pred_adr));
      chk("correct_pc", correct_pc, e_cpc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one resolving jump, check its outputs at mid-cycle, leave after the capture edge
  task automatic resolve(input string nm, input logic [15:0] pc, input logic tk,
                         input logic [15:0] tgt, input logic pr, input logic [15:0] padr,
                         input logic em, input logic ea, input logic [15:0] ec);
    resolve_valid    = 1'b1;
    resolve_pc       = pc;
    resolve_taken    = tk;
    resolve_target   = tgt;
    resolve_pred     = pr;
    resolve_pred_adr = padr;
    @(negedge clk);
    chk({nm, "_miss"}, jump_pred_miss, em);
    chk({nm, "_adr_miss"}, jump_pred_adr_miss, ea);
    chk({nm, "_cpc"}, correct_pc, ec);
    tick();
    resolve_valid = 1'b0;
  endtask

  task automatic look(input string nm, input logic [15:0] pc, input logic ejp,
                      input logic [15:0] eadr);
    pc_if = pc;
    @(negedge clk);
    chk({nm, "_jp"}, jump_pred, ejp);
    chk({nm, "_adr"}, pred_adr, eadr);
    tick();
  endtask

  task automatic clear_phase(input string nm);
    for (int k = 0; k < 16; k++) begin
      pc_if = 16'(k * 17);
      @(negedge clk);
      chk({nm, "_busy"}, jump_pred_busy, 1'b1);
      chk({nm, "_jp"}, jump_pred, 1'b0);
      tick();
    end
    @(negedge clk);
    chk({nm, "_done"}, jump_pred_busy, 1'b0);
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    pc_if = '0;
    resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0;
    resolve_target = '0; resolve_pred = 1'b0; resolve_pred_adr = '0;
    #2 rst_n = 1'b0;
    run_chk = 1'b1;
    @(negedge clk);
    chk("rst_busy", jump_pred_busy, 1'b1);
    chk("rst_jp", jump_pred, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    clear_phase("clr1");

    // Cold taken branch allocates with ctr=2
    resolve("t2", 16'h0013, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040);
    tick();
    look("t2", 16'h0013, 1'b1, 16'h0040);

    // Not taken: ctr 2->1
    resolve("t3", 16'h0013, 1'b0, 16'h0040, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0014);
    tick();
    look("t3", 16'h0013, 1'b0, 16'h0040);

    // Right direction, wrong target
    resolve("t4", 16'h0013, 1'b1, 16'h0050, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0050);
    tick();
    look("t4", 16'h0013, 1'b1, 16'h0050);

    // Alias evicts, then saturation
    resolve("t5a", 16'h0023, 1'b1, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0080);
    tick();
    look("t5evict", 16'h0013, 1'b0, 16'h0000);
    resolve("t5b", 16'h0023, 1'b1, 16'h0080, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0080);
    tick();
    resolve("t5c", 16'h0023, 1'b1, 16'h0080, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0080);
    tick();
    resolve("t5d", 16'h0023, 1'b0, 16'h0080, 1'b1, 16'h0080, 1'b1, 1'b0, 16'h0024);
    tick();
    look("t5sat", 16'h0023, 1'b1, 16'h0080);

    // Resolve arriving during UPD: checked but not captured
    resolve("drop1", 16'h0007, 1'b1, 16'h0070, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0070);
    resolve("drop2", 16'h0008, 1'b1, 16'h0088, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0088);
    tick();
    look("drop8", 16'h0008, 1'b0, 16'h0000);
    look("keep7", 16'h0007, 1'b1, 16'h0070);

    // Reset during UPD discards the pending write
    resolve("t6a", 16'h0005, 1'b1, 16'h0099, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0099);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6rst_busy", jump_pred_busy, 1'b1);
    chk("t6rst_cpc", correct_pc, 16'h0000);
    tick();
    rst_n = 1'b1;
    clear_phase("clr2");
    look("t6nowr", 16'h0005, 1'b0, 16'h0000);
    look("t6gone", 16'h0023, 1'b0, 16'h0000);
    resolve("t6wrap", 16'hFFFF, 1'b0, 16'h1234, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000);
    tick();
    look("t6ffff", 16'hFFFF, 1'b0, 16'h0000);

    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
